// File: rtl/pipe_hazard_ctrl.sv
// Pipeline-control unit for the LC-3b pipelined datapath: per-register load enables, valid bits, bubbles,
// branch flush, load-use interlock and EX forwarding selects. Perf counters built only with PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int NUM_REGS = 4,
    parameter int MEM_IDX  = 2,
    parameter int BR_IDX   = 3,
    parameter int REG_W    = 3,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                imem_resp,
    input  logic                mem_stall,
    input  logic                branch_taken,
    input  logic [REG_W-1:0]    if_id_sr1,
    input  logic [REG_W-1:0]    if_id_sr2,
    input  logic                if_id_use1,
    input  logic                if_id_use2,
    input  logic [REG_W-1:0]    id_ex_dest,
    input  logic                id_ex_wr,
    input  logic                id_ex_is_load,
    input  logic [REG_W-1:0]    id_ex_sr1,
    input  logic [REG_W-1:0]    id_ex_sr2,
    input  logic [REG_W-1:0]    ex_mem_dest,
    input  logic [REG_W-1:0]    mem_wb_dest,
    input  logic                ex_mem_wr,
    input  logic                mem_wb_wr,
    output logic                load_pc,
    output logic                pc_redirect,
    output logic [NUM_REGS-1:0] load_reg,
    output logic [NUM_REGS-1:0] valid,
    output logic [1:0]          fwd_a_sel,
    output logic [1:0]          fwd_b_sel,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    bubble_cnt,
    output logic [CNT_W-1:0]    flush_cnt
);

    logic [NUM_REGS-1:0] r_valid;
    logic [NUM_REGS-1:0] w_valid_nxt;
    logic [NUM_REGS-1:0] w_valid_prev;
    logic [NUM_REGS-1:0] w_load_reg;
    logic                w_br;
    logic                w_lu;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] src,
        input logic             v_exmem,
        input logic             v_memwb
    );
        if (v_exmem && ex_mem_wr && (ex_mem_dest == src))
            return 2'd1;
        else if (v_memwb && mem_wb_wr && (mem_wb_dest == src))
            return 2'd2;
        else
            return 2'd0;
    endfunction

    assign w_br = branch_taken & r_valid[BR_IDX];
    assign w_lu = r_valid[1] & id_ex_is_load & id_ex_wr & r_valid[0] &
                  ((if_id_use1 & (if_id_sr1 == id_ex_dest)) |
                   (if_id_use2 & (if_id_sr2 == id_ex_dest)));

    assign w_valid_prev = {r_valid[NUM_REGS-2:0], 1'b0};

    // A taken branch always refetches, even over a memory stall or load-use hold.
    assign pc_redirect = w_br;
    assign load_pc     = w_br | (~mem_stall & ~w_lu & imem_resp);
    assign load_reg    = w_load_reg;
    assign valid       = r_valid;

    always_comb begin
        w_load_reg  = '1;
        w_valid_nxt = r_valid;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i > MEM_IDX + 1) begin
                w_valid_nxt[i] = w_valid_prev[i];
            end else if (i == MEM_IDX + 1) begin
                w_valid_nxt[i] = mem_stall ? 1'b0 : w_valid_prev[i];
            end else if (mem_stall) begin
                w_load_reg[i]  = 1'b0;
                w_valid_nxt[i] = r_valid[i];
            end else if (i == 0) begin
                w_load_reg[i]  = ~w_lu;
                w_valid_nxt[i] = w_lu ? r_valid[i] : imem_resp;
            end else if (i == 1) begin
                w_valid_nxt[i] = w_lu ? 1'b0 : w_valid_prev[i];
            end else begin
                w_valid_nxt[i] = w_valid_prev[i];
            end
            // Flush clears younger slots even when their load enable is low.
            if (w_br && (i < BR_IDX))
                w_valid_nxt[i] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_valid <= '0;
        else
            r_valid <= w_valid_nxt;
    end

    assign fwd_a_sel = fwd_sel(id_ex_sr1, r_valid[2], r_valid[3]);
    assign fwd_b_sel = fwd_sel(id_ex_sr2, r_valid[2], r_valid[3]);

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_stall_ev;
    logic             w_bubble_ev;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != {CNT_W{1'b1}}))
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        else
            return v;
    endfunction

    assign w_stall_ev  = mem_stall | w_lu;
    assign w_bubble_ev = ~w_br & ~mem_stall & ~w_lu & ~imem_resp;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            r_stall_cnt  <= sat_inc(r_stall_cnt, w_stall_ev);
            r_bubble_cnt <= sat_inc(r_bubble_cnt, w_bubble_ev);
            r_flush_cnt  <= sat_inc(r_flush_cnt, w_br);
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
    assign flush_cnt  = r_flush_cnt;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
    assign flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a slot-level pipeline model.
module tb_pipe_hazard_ctrl;

    localparam int NR    = 4;
    localparam int MEM   = 2;
    localparam int BR    = 3;
    localparam int RW    = 3;
    localparam int CW    = 32;
`ifdef PIPE_PERF_CNT_EN
    localparam int CNT_ON = 1;
`else
    localparam int CNT_ON = 0;
`endif

    logic          clk;
    logic          reset_n;
    logic          imem_resp, mem_stall, branch_taken;
    logic [RW-1:0] if_id_sr1, if_id_sr2, id_ex_dest, id_ex_sr1, id_ex_sr2, ex_mem_dest, mem_wb_dest;
    logic          if_id_use1, if_id_use2, id_ex_wr, id_ex_is_load, ex_mem_wr, mem_wb_wr;
    logic          load_pc, pc_redirect;
    logic [NR-1:0] load_reg, valid;
    logic [1:0]    fwd_a_sel, fwd_b_sel;
    logic [CW-1:0] stall_cnt, bubble_cnt, flush_cnt;

    int n_checks = 0;
    int n_errors = 0;

    pipe_hazard_ctrl #(.NUM_REGS(NR), .MEM_IDX(MEM), .BR_IDX(BR), .REG_W(RW), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .imem_resp(imem_resp), .mem_stall(mem_stall),
        .branch_taken(branch_taken), .if_id_sr1(if_id_sr1), .if_id_sr2(if_id_sr2),
        .if_id_use1(if_id_use1), .if_id_use2(if_id_use2), .id_ex_dest(id_ex_dest),
        .id_ex_wr(id_ex_wr), .id_ex_is_load(id_ex_is_load), .id_ex_sr1(id_ex_sr1),
        .id_ex_sr2(id_ex_sr2), .ex_mem_dest(ex_mem_dest), .mem_wb_dest(mem_wb_dest),
        .ex_mem_wr(ex_mem_wr), .mem_wb_wr(mem_wb_wr), .load_pc(load_pc),
        .pc_redirect(pc_redirect), .load_reg(load_reg), .valid(valid),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall_cnt(stall_cnt),
        .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Model state: one valid flag per pipeline slot plus event tallies.
    logic [NR-1:0] m_valid;
    logic [NR-1:0] m_nv;
    logic [NR-1:0] m_lr;
    int            m_stall, m_bubble, m_flush;
    logic          m_br, m_lu;
    int            m_hold;

    function automatic logic [1:0] exp_fwd(input logic [RW-1:0] src, input logic [NR-1:0] v);
        if (v[2] && ex_mem_wr && ex_mem_dest == src) return 2'd1;
        if (v[3] && mem_wb_wr && mem_wb_dest == src) return 2'd2;
        return 2'd0;
    endfunction

    // m_hold = highest slot that must keep its contents this cycle (-1 = everything moves).
    always @(negedge clk) begin
        if (!reset_n) begin
            m_valid  = '0;
            m_stall  = 0;
            m_bubble = 0;
            m_flush  = 0;
            chk("rst_valid", valid, 0);
            chk("rst_cnt", {stall_cnt | bubble_cnt | flush_cnt}, 0);
        end else begin
            m_br = branch_taken && m_valid[BR];
            m_lu = m_valid[0] && m_valid[1] && id_ex_is_load && id_ex_wr &&
                   ((if_id_use1 && if_id_sr1 == id_ex_dest) || (if_id_use2 && if_id_sr2 == id_ex_dest));
            m_hold = mem_stall ? MEM : (m_lu ? 0 : -1);
            for (int i = 0; i < NR; i++) begin
                m_lr[i] = (i > m_hold);
                if (i <= m_hold)          m_nv[i] = m_valid[i];
                else if (i == m_hold + 1) m_nv[i] = (m_hold < 0) ? imem_resp : 1'b0;
                else                      m_nv[i] = m_valid[i-1];
                if (m_br && i < BR)       m_nv[i] = 1'b0;
            end
            chk("m_valid", valid, m_valid);
            chk("m_load_reg", load_reg, m_lr);
            chk("m_load_pc", load_pc, m_br || (m_hold < 0 && imem_resp));
            chk("m_redirect", pc_redirect, m_br);
            chk("m_fwd_a", fwd_a_sel, exp_fwd(id_ex_sr1, m_valid));
            chk("m_fwd_b", fwd_b_sel, exp_fwd(id_ex_sr2, m_valid));
            chk("m_stall_cnt", stall_cnt, CNT_ON * m_stall);
            chk("m_bubble_cnt", bubble_cnt, CNT_ON * m_bubble);
            chk("m_flush_cnt", flush_cnt, CNT_ON * m_flush);
            if (mem_stall || m_lu) m_stall++;
            if (!m_br && m_hold < 0 && !imem_resp) m_bubble++;
            if (m_br) m_flush++;
            m_valid = m_nv;
        end
    end

    task automatic quiet();
        imem_resp = 1'b1; mem_stall = 1'b0; branch_taken = 1'b0;
        if_id_use1 = 1'b0; if_id_use2 = 1'b0; id_ex_wr = 1'b0; id_ex_is_load = 1'b0;
        ex_mem_wr = 1'b0; mem_wb_wr = 1'b0;
        if_id_sr1 = 0; if_id_sr2 = 0; id_ex_dest = 0; id_ex_sr1 = 0; id_ex_sr2 = 0;
        ex_mem_dest = 0; mem_wb_dest = 0;
    endtask

    initial begin
        reset_n = 1'b0;
        quiet();
        repeat (3) cyc();
        reset_n = 1'b1;
        cyc(); chk("fill1", valid, 4'b0001);
        cyc(); chk("fill2", valid, 4'b0011);
        cyc(); chk("fill3", valid, 4'b0111);
        cyc(); chk("fill4", valid, 4'b1111);

        // Asynchronous reset in the middle of a memory stall
        mem_stall = 1'b1;
        #2 chk("stall_lr", load_reg, 4'b1000);
        reset_n = 1'b0;
        #1 chk("arst_valid", valid, 4'b0000);
        chk("arst_stall_cnt", stall_cnt, 0);
        cyc();
        mem_stall = 1'b0;
        reset_n = 1'b1;
        cyc(); chk("refill1", valid, 4'b0001);
        cyc(); chk("refill2", valid, 4'b0011);
        cyc(); chk("refill3", valid, 4'b0111);
        cyc(); chk("refill4", valid, 4'b1111);

        // Load-use on R3
        id_ex_is_load = 1'b1; id_ex_wr = 1'b1; id_ex_dest = 3'd3;
        if_id_sr1 = 3'd3; if_id_use1 = 1'b1;
        #2 chk("lu_load_pc", load_pc, 1'b0);
        chk("lu_load_reg", load_reg, 4'b1110);
        cyc();
        chk("lu_bubble", valid[1], 1'b0);
        chk("lu_release", load_reg, 4'b1111);
        chk("lu_stall_cnt", stall_cnt, CNT_ON * 1);
        quiet();
        repeat (4) cyc();
        chk("pre_bubble", valid, 4'b1111);

        // Fetch bubbles, with forwarding probed as the bubble walks down
        imem_resp = 1'b0;
        #2 chk("fb1_load_reg", load_reg, 4'b1111);
        chk("fb1_load_pc", load_pc, 1'b0);
        cyc(); chk("fb1_valid", valid, 4'b1110);
        #2 chk("fb2_load_reg", load_reg, 4'b1111);
        cyc(); chk("fb2_valid", valid, 4'b1100);
        chk("fb_bubble_cnt", bubble_cnt, CNT_ON * 2);
        imem_resp = 1'b1;
        id_ex_sr1 = 3'd2; ex_mem_dest = 3'd2; mem_wb_dest = 3'd2;
        ex_mem_wr = 1'b1; mem_wb_wr = 1'b1; id_ex_sr2 = 3'd5;
        #2 chk("fwd_exmem", fwd_a_sel, 2'd1);
        chk("fwd_b_none", fwd_b_sel, 2'd0);
        cyc(); chk("fb_shift", valid, 4'b1001);
        #2 chk("fwd_memwb", fwd_a_sel, 2'd2);
        mem_wb_wr = 1'b0;
        #1 chk("fwd_rf", fwd_a_sel, 2'd0);
        quiet();
        repeat (4) cyc();
        chk("pre_mstall", valid, 4'b1111);

        // Three-cycle memory stall
        mem_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #2 chk("ms_load_reg", load_reg, 4'b1000);
            chk("ms_load_pc", load_pc, 1'b0);
            cyc();
            chk("ms_valid", valid, 4'b0111);
        end
        chk("ms_stall_cnt", stall_cnt, CNT_ON * 4);
        mem_stall = 1'b0;
        cyc(); chk("post_ms", valid, 4'b1111);

        // Branch during a memory stall, then the same request with no valid branch
        branch_taken = 1'b1; mem_stall = 1'b1;
        #2 chk("br_redirect", pc_redirect, 1'b1);
        chk("br_load_pc", load_pc, 1'b1);
        cyc();
        chk("br_flush_valid", valid, 4'b0000);
        chk("br_flush_cnt", flush_cnt, CNT_ON * 1);
        #2 chk("nbr_redirect", pc_redirect, 1'b0);
        chk("nbr_load_pc", load_pc, 1'b0);
        cyc();
        chk("nbr_flush_cnt", flush_cnt, CNT_ON * 1);
        quiet();

        // Randomized traffic; the negedge model checks every cycle
        for (int n = 0; n < 3000; n++) begin
            cyc();
            reset_n       = ($urandom_range(0, 249) != 0);
            imem_resp     = ($urandom_range(0, 4) != 0);
            mem_stall     = ($urandom_range(0, 5) == 0);
            branch_taken  = ($urandom_range(0, 7) == 0);
            if_id_use1    = $urandom_range(0, 1);
            if_id_use2    = $urandom_range(0, 1);
            id_ex_wr      = $urandom_range(0, 1);
            id_ex_is_load = $urandom_range(0, 1);
            ex_mem_wr     = $urandom_range(0, 1);
            mem_wb_wr     = $urandom_range(0, 1);
            if_id_sr1     = RW'($urandom_range(0, 3));
            if_id_sr2     = RW'($urandom_range(0, 3));
            id_ex_dest    = RW'($urandom_range(0, 3));
            id_ex_sr1     = RW'($urandom_range(0, 3));
            id_ex_sr2     = RW'($urandom_range(0, 3));
            ex_mem_dest   = RW'($urandom_range(0, 3));
            mem_wb_dest   = RW'($urandom_range(0, 3));
        end
        cyc();
        reset_n = 1'b1;
        cyc();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
